// File: rtl/seg_scan_controller.sv
// Scan sequencer for a 4-digit multiplexed 7-segment display: double-buffered digit bank,
// frame-aligned publish, per-slot blanking gap, 3-bit PWM brightness, active-low segment decode.
module seg_scan_controller #(
  parameter int SLOT_CYCLES  = 13,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_digit,
  input  logic [3:0] wr_value,
  input  logic       wr_dp,
  input  logic       commit,
  input  logic [2:0] brightness,
  output logic [3:0] digits,
  output logic [7:0] segments,
  output logic       frame_tick
);

  // state   | meaning
  // S_BLANK | first BLANK_CYCLES of a slot, all digits off
  // S_ON    | rest of the slot, current digit enabled, segments PWM-gated
  typedef enum logic {S_BLANK, S_ON} state_t;

  localparam int            CW       = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ON   = CW'(BLANK_CYCLES);
  localparam logic [4:0]    BLANK_E  = 5'h0A;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_idx, w_idx_nxt;
  logic [2:0]    r_p, w_p_nxt;
  logic [2:0]    r_bright, w_bright_nxt;
  logic          r_pending;
  logic [4:0]    r_shadow [4];
  logic [4:0]    r_active [4];
  logic [3:0]    r_digits, w_digits_nxt;
  logic [7:0]    r_segments, w_seg_nxt;
  logic          r_frame_tick, w_tick_nxt;
  logic          w_cnt_last;
  logic          w_on_entry;
  logic          w_wr_acc;

  function automatic logic [7:0] seg_decode(input logic [4:0] e);
    logic [6:0] gfedcba;
    case (e[3:0])
      4'h0: gfedcba = 7'h40;
      4'h1: gfedcba = 7'h79;
      4'h2: gfedcba = 7'h24;
      4'h3: gfedcba = 7'h30;
      4'h4: gfedcba = 7'h19;
      4'h5: gfedcba = 7'h12;
      4'h6: gfedcba = 7'h02;
      4'h7: gfedcba = 7'h78;
      4'h8: gfedcba = 7'h00;
      4'h9: gfedcba = 7'h10;
      default: gfedcba = 7'h7F;
    endcase
    // Test pattern lights everything, decimal point included.
    if (e[3:0] == 4'hF) return 8'h00;
    return {~e[4], gfedcba};
  endfunction

  always_comb begin
    w_cnt_last   = (r_cnt == CNT_LAST);
    w_cnt_nxt    = w_cnt_last ? '0 : r_cnt + CW'(1);
    w_idx_nxt    = w_cnt_last ? r_idx + 2'd1 : r_idx;
    w_state_nxt  = r_state;
    if (w_cnt_last)
      w_state_nxt = S_BLANK;
    else if (w_cnt_nxt == CNT_ON)
      w_state_nxt = S_ON;

    w_on_entry   = (r_state == S_BLANK) && (w_state_nxt == S_ON);
    w_p_nxt      = r_p;
    w_bright_nxt = r_bright;
    if (w_on_entry) begin
      w_p_nxt      = '0;
      w_bright_nxt = brightness;
    end else if (r_state == S_ON) begin
      w_p_nxt = r_p + 3'd1;
    end

    // Output registers load the value belonging to the next cycle's state.
    w_digits_nxt = '0;
    w_seg_nxt    = 8'hFF;
    if (w_state_nxt == S_ON) begin
      w_digits_nxt = 4'b0001 << w_idx_nxt;
      if (w_p_nxt <= w_bright_nxt)
        w_seg_nxt = seg_decode(r_active[w_idx_nxt]);
    end
    w_tick_nxt = (w_idx_nxt == 2'd3) && (w_cnt_nxt == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_BLANK;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_p          <= '0;
      r_bright     <= '0;
      r_digits     <= '0;
      r_segments   <= 8'hFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_p          <= w_p_nxt;
      r_bright     <= w_bright_nxt;
      r_digits     <= w_digits_nxt;
      r_segments   <= w_seg_nxt;
      r_frame_tick <= w_tick_nxt;
    end
  end

  assign w_wr_acc = wr_valid & ~r_pending;

  // r_frame_tick marks the last cycle of the frame, so its edge is the publish point.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= BLANK_E;
        r_active[i] <= BLANK_E;
      end
    end else begin
      if (r_frame_tick && r_pending) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end else if (commit && !r_pending) begin
        r_pending <= 1'b1;
      end
      if (w_wr_acc)
        r_shadow[wr_digit] <= {wr_dp, wr_value};
    end
  end

  assign wr_ready   = ~r_pending;
  assign digits     = r_digits;
  assign segments   = r_segments;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: directed scenarios plus random traffic, every cycle compared
// against a cycle-position model (frame arithmetic) of the display and the write/commit banks.
module tb_seg_scan_controller;
  localparam int SLOT  = 13;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst_n, wr_valid, wr_ready, wr_dp, commit, frame_tick;
  logic [1:0] wr_digit;
  logic [3:0] wr_value, digits;
  logic [2:0] brightness;
  logic [7:0] segments;

  always #5 clk = ~clk;

  seg_scan_controller #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_digit(wr_digit), .wr_value(wr_value), .wr_dp(wr_dp), .commit(commit),
    .brightness(brightness), .digits(digits), .segments(segments), .frame_tick(frame_tick)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Model: t = cycles since reset released (cycle 0 = first cycle with cnt 0).
  int         t = 0;
  logic [4:0] m_sh [4];
  logic [4:0] m_act [4];
  bit         m_pend = 0;
  int         m_bright = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
  endtask

  function automatic logic [7:0] seg_of(input logic [4:0] e);
    logic [7:0] tbl [10];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    if (e[3:0] == 4'hF) return 8'h00;
    if (e[3:0] >= 4'hA) return e[4] ? 8'h7F : 8'hFF;
    return e[4] ? (tbl[e[3:0]] & 8'h7F) : tbl[e[3:0]];
  endfunction

  task automatic cyc();
    bit         old_pend;
    int         slot, idx;
    logic [3:0] e_dig;
    logic [7:0] e_seg;
    @(posedge clk);
    if (!rst_n) begin
      t = 0;
      m_pend = 0;
      for (int i = 0; i < 4; i++) begin m_sh[i] = 5'h0A; m_act[i] = 5'h0A; end
    end else begin
      old_pend = m_pend;
      if ((t % FRAME) == FRAME - 1 && old_pend) begin
        m_act = m_sh;
        m_pend = 0;
      end else if (commit && !old_pend) begin
        m_pend = 1;
      end
      if (wr_valid && !old_pend) m_sh[wr_digit] = {wr_dp, wr_value};
      t++;
      if ((t % SLOT) == BLANK) m_bright = brightness;
    end
    #1;
    slot = t % SLOT;
    idx  = (t / SLOT) % 4;
    e_dig = 4'h0;
    e_seg = 8'hFF;
    if (slot >= BLANK) begin
      e_dig = 4'(1 << idx);
      if (((slot - BLANK) % 8) <= m_bright) e_seg = seg_of(m_act[idx]);
    end
    chk("digits", 32'(digits), 32'(e_dig));
    chk("segments", 32'(segments), 32'(e_seg));
    chk("frame_tick", 32'(frame_tick), 32'((idx == 3 && slot == SLOT - 1) ? 1 : 0));
    chk("wr_ready", 32'(wr_ready), 32'(m_pend ? 0 : 1));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic wait_phase(input int ph);
    for (int k = 0; k < FRAME && (t % FRAME) != ph; k++) cyc();
    chk("phase_reached", 32'(t % FRAME), 32'(ph));
  endtask

  task automatic wr(input int d, input int v, input bit dp, input bit cm);
    wr_valid = 1; wr_digit = 2'(d); wr_value = 4'(v); wr_dp = dp; commit = cm;
    cyc();
    wr_valid = 0; commit = 0;
  endtask

  initial begin
    rst_n = 0; wr_valid = 0; wr_digit = 0; wr_value = 0; wr_dp = 0; commit = 0;
    brightness = 3'd7;
    run(3);
    rst_n = 1;
    run(FRAME);

    // Digits 3,3,6,3 then commit at full brightness.
    wr(0, 3, 0, 0); wr(1, 3, 0, 0); wr(2, 6, 0, 0); wr(3, 3, 0, 0);
    commit = 1; cyc(); commit = 0;
    run(2 * FRAME);

    brightness = 3'd0; run(FRAME);
    brightness = 3'd3; run(FRAME);
    brightness = 3'd7; run(FRAME);

    // Writes held while pending, plus a redundant commit.
    commit = 1; cyc(); commit = 0;
    wr_valid = 1; wr_digit = 2'd1; wr_value = 4'd9; wr_dp = 1;
    run(10);
    commit = 1; cyc(); commit = 0;
    run(FRAME);
    wr_valid = 0;
    run(FRAME);

    // Blank-with-dp, test pattern, and same-cycle write + commit.
    wr(0, 4'hC, 1, 0);
    wr(1, 4'hF, 1, 1);
    run(2 * FRAME);

    // Commit + write during the frame_tick cycle lands one frame later.
    wait_phase(FRAME - 1);
    wr(2, 5, 0, 1);
    run(2 * FRAME + 3);

    // Reset in the middle of digit 2's ON phase with a commit pending.
    wr(3, 8, 1, 1);
    wait_phase(2 * SLOT + 5);
    rst_n = 0; cyc(); rst_n = 1;
    run(FRAME + 4);

    for (int k = 0; k < 3000; k++) begin
      wr_valid   = ($urandom_range(0, 9) < 3);
      wr_digit   = 2'($urandom_range(0, 3));
      wr_value   = 4'($urandom_range(0, 15));
      wr_dp      = 1'($urandom_range(0, 1));
      commit     = ($urandom_range(0, 19) == 0);
      rst_n      = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 99) == 0) brightness = 3'($urandom_range(0, 7));
      cyc();
    end
    rst_n = 1; wr_valid = 0; commit = 0;
    run(FRAME);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
